// File: rtl/an_sec_locator_corrector_pkg.sv
// an_sec_pkg: shared constants, FSM states and status codes for the AN-code single-error corrector.
package an_sec_pkg;
  localparam int N_BITS = 68;
  localparam int A = 50861;
  localparam int R_W = 16;
  localparam int L_W = 8;
  typedef enum logic [2:0] {IDLE, RESID, CHECK, SEARCH, CORRECT, DONE} state_e;
  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;
endpackage

// File: rtl/an_sec_locator_corrector_residue_serial.sv
// an_residue_serial: MSB-first bit-serial reduction mod A; 2r+bit < 2A so one conditional subtract suffices.
module an_residue_serial
  import an_sec_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           en,
  input  logic           bit_in,
  output logic [R_W-1:0] r_out
);
  logic [R_W-1:0] r_q, r_d;
  logic [R_W:0] s;
  always_comb begin
    s = {r_q, bit_in};
    r_d = start ? '0 : en ? (s >= (R_W+1)'(A) ? R_W'(s - (R_W+1)'(A)) : s[R_W-1:0]) : r_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else r_q <= r_d;
  assign r_out = r_q;
endmodule

// File: rtl/an_sec_locator_corrector.sv
// an_sec_locator_corrector: computes the mod-A residue of a received AN codeword, locates a single
// +/-2^k error by regenerating powers of two mod A, and emits the corrected word with location and status.
module an_sec_locator_corrector
  import an_sec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     cw_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_BITS-1:0]     cw_out,
  output logic signed [L_W-1:0] err_loc,
  output logic [1:0]            status,
  output logic                  busy
);
  state_e state_q, state_d;
  logic [N_BITS-1:0] cw_q, cw_d, cw_out_q, cw_out_d, one_hot;
  logic [6:0] cnt_q, cnt_d, mag_q, mag_d;
  logic [R_W-1:0] p_q, p_d, r;
  logic [R_W:0] p2;
  logic neg_q, neg_d, hit_p, hit_n;
  logic signed [L_W-1:0] err_loc_q, err_loc_d;
  logic [1:0] status_q, status_d;
  an_residue_serial u_res (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_q == IDLE && in_valid),
    .en    (state_q == RESID),
    .bit_in(cw_q[cnt_q]),
    .r_out (r)
  );
  assign p2 = {p_q, 1'b0};
  assign hit_p = r == p_q;
  assign hit_n = r == R_W'(A) - p_q;
  assign one_hot = {{(N_BITS-1){1'b0}}, 1'b1} << (mag_q - 7'd1);
  always_comb begin
    state_d = state_q;
    cw_d = cw_q;
    cnt_d = cnt_q;
    p_d = p_q;
    mag_d = mag_q;
    neg_d = neg_q;
    cw_out_d = cw_out_q;
    err_loc_d = err_loc_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RESID;
        cw_d = cw_in;
        cnt_d = 7'(N_BITS - 1);
      end
      RESID: begin
        cnt_d = cnt_q - 7'd1;
        state_d = cnt_q == 7'd0 ? CHECK : RESID;
      end
      CHECK: if (r == '0) begin
        state_d = DONE;
        status_d = ST_CLEAN;
        err_loc_d = '0;
        cw_out_d = cw_q;
      end else begin
        state_d = SEARCH;
        cnt_d = 7'd1;
        p_d = R_W'(1);
      end
      SEARCH: if (hit_p || hit_n) begin
        state_d = CORRECT;
        mag_d = cnt_q;
        neg_d = !hit_p;
      end else if (cnt_q == 7'(N_BITS)) begin
        state_d = DONE;
        status_d = ST_UNCORR;
        err_loc_d = '0;
        cw_out_d = cw_q;
      end else begin
        p_d = p2 >= (R_W+1)'(A) ? R_W'(p2 - (R_W+1)'(A)) : p2[R_W-1:0];
        cnt_d = cnt_q + 7'd1;
      end
      // Correction wraps mod 2^N_BITS; a wrapped result is a silent miscorrection.
      CORRECT: begin
        state_d = DONE;
        status_d = ST_CORR;
        err_loc_d = neg_q ? -L_W'(mag_q) : L_W'(mag_q);
        cw_out_d = neg_q ? cw_q + one_hot : cw_q - one_hot;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cw_q <= '0;
      cnt_q <= '0;
      p_q <= '0;
      mag_q <= '0;
      neg_q <= 1'b0;
      cw_out_q <= '0;
      err_loc_q <= '0;
      status_q <= ST_CLEAN;
    end else begin
      state_q <= state_d;
      cw_q <= cw_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      mag_q <= mag_d;
      neg_q <= neg_d;
      cw_out_q <= cw_out_d;
      err_loc_q <= err_loc_d;
      status_q <= status_d;
    end
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign cw_out = cw_out_q;
  assign err_loc = err_loc_q;
  assign status = status_q;
endmodule

// File: doc/an_sec_locator_corrector.md
Name: an_sec_locator_corrector

Overview:
- Sequential single-error-correction front end for the 68-bit product (AN) code: 52 data bits, check constant A = 50861.
- Accepts a received codeword and computes its residue mod A bit-serially.
- Searches for the single-error location l in ±1..±68 by regenerating ±2^(|l|-1) mod A, then emits the corrected codeword, l and a status code.
- Sits between the memory/channel read port and the AN decoder (division by A).

Parameters:
- N_BITS, 68, codeword width
- A, 50861, AN check constant (odd)
- R_W, 16, residue width
- L_W, 8, signed width of err_loc

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword offered
- in_ready  out  1  block idle, can accept
- cw_in  in  N_BITS  received codeword
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- cw_out  out  N_BITS  corrected codeword (unchanged if clean or uncorrectable)
- err_loc  out  L_W (signed)  error location; +k means +2^(k-1) error, -k means -2^(k-1) error, 0 means none
- status  out  2  00 clean, 01 corrected, 10 uncorrectable
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset (async, any state): state=IDLE; r, p, counters and cw register cleared. Outputs: out_valid=0, cw_out=0, err_loc=0, status=00, busy=0, in_ready=1. An in-flight word is discarded.
- IDLE: in_ready=1. On in_valid&&in_ready, latch cw_in, r=0, bit counter=N_BITS-1, go to RESID. Accept edge is edge 0.
- RESID: one bit per cycle, MSB first, r <= (2r + bit) mod A.
  - 2r+bit < 2A, so the reduction is a single conditional subtract on a 17-bit intermediate.
  - Runs edges 1..68, then goes to CHECK.
- CHECK (edge 69):
  - r==0: go to DONE with status 00, err_loc 0, cw_out=cw.
  - Otherwise: go to SEARCH with i=1, p=1.
- SEARCH: one candidate per cycle.
  - r==p gives l=+i; else r==A-p gives l=-i. Positive compare has priority.
  - On match, go to CORRECT.
  - Otherwise p <= 2p mod A (single conditional subtract), i <= i+1.
  - If i==68 with no match, go to DONE with status 10, err_loc 0, cw_out=cw.
- CORRECT: 1 cycle, then DONE with status 01.
  - l>0: cw_out = cw - 2^(l-1).
  - l<0: cw_out = cw + 2^(-l-1).
  - Arithmetic is mod 2^N_BITS; wrap is a silent miscorrection, no extra flag.
- DONE: out_valid=1; cw_out, err_loc and status held stable until out_ready. On out_valid&&out_ready go to IDLE, out_valid=0.
  - in_ready=0 in every non-IDLE state; in_valid there is ignored.
  - The next accept can occur at the earliest on the cycle after the handshake.
- Latency (accept edge = 0; out_valid high after edge):
  - clean: edge 69
  - match at |l|=k: edge 70+k
  - uncorrectable: edge 137
- Residue values never exceed A-1; the p sequence never reaches 0 because A is odd.

Decomposition:
- Package an_sec_pkg:
  - constants A, N_BITS, R_W, L_W
  - state enum {IDLE, RESID, CHECK, SEARCH, CORRECT, DONE}
  - status codes ST_CLEAN, ST_CORR, ST_UNCORR
- One sub-module, an_residue_serial: bit-serial mod-A reducer with start, bit_in, r_out. It is reused by the encoder self-check.
- The doubling-mod-A generator stays inline.

Test Plan:
- cw_in=0 -> status 00, err_loc 0, cw_out 0, out_valid after edge 69.
- cw_in=50861000+16 (r=16) -> err_loc +5, status 01, cw_out 50861000, out_valid after edge 75.
- cw_in=254305-65536=188769 (r=36186) -> err_loc -17, status 01, cw_out 254305, out_valid after edge 87.
- cw_in=2^67 (r=38181) -> err_loc +68, status 01, cw_out 0, out_valid after edge 138. cw_in=3 -> status 10, err_loc 0, cw_out 3, out_valid after edge 137.
- Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no second accept; accept occurs only after the handshake.
- Drop rst_n mid-SEARCH -> same cycle out_valid=0, busy=0, in_ready=1. The next word 50861000+16 is corrected correctly with latency unchanged.
